// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller: default widths,
// controller state encoding and a small state classification helper.
package counter_seq_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 3;
    localparam int unsigned DEF_REP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // States in which a sequence is considered in progress.
    function automatic logic is_busy(input state_t s);
        return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/counter_seq_ctrl_count_core.sv
// WIDTH-bit wrap-at-limit counter: async active-low clear, synchronous clear,
// count enable and a terminal-count flag (q == limit).
module count_core #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             clrbar,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             term
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next count: clear wins, otherwise advance and wrap to 0 at the limit.
    always_comb begin
        q_d  = q_q;
        term = (q_q == limit);
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = term ? '0 : q_q + 1'b1;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge clrbar) begin
        if (!clrbar) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller: runs the count core from 0 to a latched terminal
// value for a latched number of periods, with hold, abort, period tick and
// completion pulse. All outputs are registered.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             clrbar,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic [WIDTH-1:0] limit,
    input  logic [REP_W-1:0] reps,
    output logic [WIDTH-1:0] q,
    output logic [REP_W-1:0] rep_cnt,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] limit_r_q, limit_r_d;
    logic [REP_W-1:0] reps_r_q,  reps_r_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             busy_q,    busy_d;
    logic             tick_q,    tick_d;
    logic             done_q,    done_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_term;

    count_core #(
        .WIDTH (WIDTH)
    ) u_count_core (
        .clk    (clk),
        .clrbar (clrbar),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .limit  (limit_r_q),
        .q      (q),
        .term   (cnt_term)
    );

    // Next-state, counter control and registered-output next values.
    always_comb begin
        state_d   = state_q;
        limit_r_d = limit_r_q;
        reps_r_d  = reps_r_q;
        rep_cnt_d = rep_cnt_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort && (reps != '0)) begin
                    state_d   = ST_LOAD;
                    limit_r_d = limit;
                    reps_r_d  = reps;
                    rep_cnt_d = '0;
                    cnt_clr   = 1'b1;
                end
            end
            ST_LOAD: begin
                cnt_clr = 1'b1;
                state_d = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (hold) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_term) begin
                        tick_d    = 1'b1;
                        rep_cnt_d = rep_cnt_q + 1'b1;
                        // Compare the incremented value so rep_cnt never wraps.
                        if (rep_cnt_d == reps_r_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (!hold) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase

        busy_d = is_busy(state_d);
    end

    // Controller state and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge clrbar) begin
        if (!clrbar) begin
            state_q   <= ST_IDLE;
            limit_r_q <= '0;
            reps_r_q  <= '0;
            rep_cnt_q <= '0;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            limit_r_q <= limit_r_d;
            reps_r_q  <= reps_r_d;
            rep_cnt_q <= rep_cnt_d;
            busy_q    <= busy_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
        end
    end

    assign rep_cnt = rep_cnt_q;
    assign busy    = busy_q;
    assign tick    = tick_q;
    assign done    = done_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: nominal vector table, hand-written corner
// sequences and randomized stimulus against a step-count reference model.
module tb_counter_seq_ctrl;

    logic       clk;
    logic       clrbar;
    logic       start;
    logic       abort;
    logic       hold;
    logic [2:0] limit;
    logic [3:0] reps;
    logic [2:0] q;
    logic [3:0] rep_cnt;
    logic       busy;
    logic       tick;
    logic       done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    counter_seq_ctrl #(
        .WIDTH (3),
        .REP_W (4)
    ) dut (
        .clk     (clk),
        .clrbar  (clrbar),
        .start   (start),
        .abort   (abort),
        .hold    (hold),
        .limit   (limit),
        .reps    (reps),
        .q       (q),
        .rep_cnt (rep_cnt),
        .busy    (busy),
        .tick    (tick),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a sequence is a number of completed RUN advances k;
    // q and rep_cnt follow from k by division by the period length.
    bit         m_act, m_load, m_held, m_fin;
    int         m_k, m_l, m_r;
    logic [2:0] e_q;
    logic [3:0] e_rep;
    logic       e_busy, e_tick, e_done;

    task automatic model_reset();
        m_act = 0; m_load = 0; m_held = 0; m_fin = 0;
        m_k = 0; m_l = 0; m_r = 0;
        e_q = '0; e_rep = '0; e_busy = 1'b0; e_tick = 1'b0; e_done = 1'b0;
    endtask

    task automatic model_edge();
        e_tick = 1'b0;
        e_done = 1'b0;
        if (m_fin) begin
            m_fin = 0;
            m_act = 0;
        end else if (!m_act) begin
            if (start && !abort && reps != 4'd0) begin
                m_act = 1; m_load = 1; m_held = 0; m_k = 0;
                m_l = int'(limit); m_r = int'(reps);
                e_q = '0; e_rep = '0; e_busy = 1'b1;
            end
        end else if (abort) begin
            m_act = 0; e_q = '0; e_busy = 1'b0;
        end else if (m_load) begin
            m_load = 0;
        end else if (m_held) begin
            if (!hold) m_held = 0;
        end else if (hold) begin
            m_held = 1;
        end else begin
            m_k++;
            e_q   = 3'(m_k % (m_l + 1));
            e_rep = 4'(m_k / (m_l + 1));
            if (m_k % (m_l + 1) == 0) begin
                e_tick = 1'b1;
                if (m_k / (m_l + 1) == m_r) begin
                    e_done = 1'b1; e_busy = 1'b0; m_fin = 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {q, rep_cnt, busy, tick, done};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got{q,rep,busy,tick,done}=%h want=%h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        chk_vec("step", {e_q, e_rep, e_busy, e_tick, e_done});
    endtask

    task automatic drive(input bit st, input bit ab, input bit hd,
                         input int lim, input int rp);
        start = st; abort = ab; hold = hd;
        limit = 3'(lim); reps = 4'(rp);
    endtask

    // Nominal run vectors: inputs before an edge, outputs expected after it.
    typedef struct {
        bit st, ab, hd;
        int lim, rp;
        int eq, erep, ebusy, etick, edone;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input int st, input int ab, input int hd,
                                input int lim, input int rp, input int eq,
                                input int er, input int eb, input int et,
                                input int ed);
        vec_t v;
        v.st = bit'(st); v.ab = bit'(ab); v.hd = bit'(hd);
        v.lim = lim; v.rp = rp;
        v.eq = eq; v.erep = er; v.ebusy = eb; v.etick = et; v.edone = ed;
        return v;
    endfunction

    int qhist[64];

    task automatic run_seq(input int lim, input int rp, input int hf,
                           input int ht, input int n,
                           output int dc, output int tk, output int mq);
        dc = -1; tk = 0; mq = 0;
        for (int c = 0; c < n; c++) begin
            drive(c == 0, 1'b0, (c >= hf) && (c <= ht), lim, rp);
            step();
            qhist[c + 1] = int'(q);
            if (done === 1'b1 && dc < 0) dc = c + 1;
            if (tick === 1'b1) tk++;
            if (int'(q) > mq) mq = int'(q);
        end
        drive(1'b0, 1'b0, 1'b0, lim, rp);
    endtask

    task automatic async_clear();
        #2 clrbar = 1'b0;
        model_reset();
        #1 chk_vec("async_clear", 11'd0);
        #1 clrbar = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int dc, tk, mq, fb;
        clrbar = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        model_reset();
        #12;
        chk_vec("reset_state", 11'd0);
        clrbar = 1'b1;

        // Nominal run limit=3 reps=2, with start-while-busy, limit/reps
        // changes after acceptance, start in DONE, abort+start and reps=0.
        tbl[0]  = mk(1, 0, 0, 3, 2, 0, 0, 1, 0, 0);
        tbl[1]  = mk(0, 0, 0, 3, 2, 0, 0, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 6, 5, 1, 0, 1, 0, 0);
        tbl[3]  = mk(1, 0, 0, 6, 5, 2, 0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 6, 5, 3, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 6, 5, 0, 1, 1, 1, 0);
        tbl[6]  = mk(0, 0, 0, 6, 5, 1, 1, 1, 0, 0);
        tbl[7]  = mk(1, 0, 0, 6, 5, 2, 1, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 6, 5, 3, 1, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 6, 5, 0, 2, 0, 1, 1);
        tbl[10] = mk(1, 0, 0, 3, 2, 0, 2, 0, 0, 0);
        tbl[11] = mk(1, 1, 0, 3, 2, 0, 2, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 3, 0, 0, 2, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].st, tbl[i].ab, tbl[i].hd, tbl[i].lim, tbl[i].rp);
            @(posedge clk);
            model_edge();
            #1;
            cyc++;
            chk_vec("table", {3'(tbl[i].eq), 4'(tbl[i].erep), 1'(tbl[i].ebusy),
                              1'(tbl[i].etick), 1'(tbl[i].edone)});
        end
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        step();

        // Unheld vs held run: hold through cycles 3-6 delays done by 5.
        run_seq(3, 1, -1, -2, 9, dc, tk, mq);
        chk("unheld_done_cycle", dc, 6);
        run_seq(3, 1, 3, 6, 14, dc, tk, mq);
        chk("held_done_cycle", dc, 11);
        chk("held_ticks", tk, 1);
        fb = 0;
        for (int c = 4; c <= 8; c++) if (qhist[c] != 1) fb++;
        chk("held_q_frozen", fb, 0);

        // limit=0: q stays 0, tick every RUN cycle, done on the fourth.
        run_seq(0, 4, -1, -2, 9, dc, tk, mq);
        chk("lim0_done_cycle", dc, 6);
        chk("lim0_ticks", tk, 4);
        chk("lim0_max_q", mq, 0);

        // limit=7: full-range count then wrap into done.
        run_seq(7, 1, -1, -2, 13, dc, tk, mq);
        chk("lim7_done_cycle", dc, 10);
        chk("lim7_ticks", tk, 1);
        chk("lim7_max_q", mq, 7);

        // Abort in RUN at q=2, rep_cnt=1.
        run_seq(3, 3, -1, -2, 8, dc, tk, mq);
        chk("abort_pre_q", int'(q), 2);
        chk("abort_pre_rep", int'(rep_cnt), 1);
        drive(1'b0, 1'b1, 1'b0, 3, 3);
        step();
        chk_vec("abort_result", {3'd0, 4'd1, 1'b0, 1'b0, 1'b0});
        drive(1'b1, 1'b1, 1'b0, 3, 3);
        step();
        chk("abort_start_idle_busy", int'(busy), 0);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        step();

        // Async clear mid-run, then a fresh start is accepted.
        run_seq(1, 3, -1, -2, 5, dc, tk, mq);
        chk("preclr_rep", int'(rep_cnt), 1);
        async_clear();
        drive(1'b1, 1'b0, 1'b0, 2, 1);
        step();
        chk("restart_busy", int'(busy), 1);
        drive(1'b0, 1'b0, 1'b0, 2, 1);
        for (int i = 0; i < 6; i++) step();

        // Randomized stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(99) < 25, $urandom_range(99) < 3,
                  $urandom_range(99) < 15, int'($urandom_range(7)),
                  int'($urandom_range(3)));
            if ($urandom_range(499) == 0) async_clear();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
